// File: rtl/sys_cmd_decoder.sv
// sys_cmd_decoder: turns received command frames into register-file
// writes/reads and ALU operations, then returns results over the TX port.
module sys_cmd_decoder #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int ALU_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic [ADDR_WIDTH-1:0] RF_Address,
   output logic                  RF_WrEn,
   output logic                  RF_RdEn,
   output logic [DATA_WIDTH-1:0] RF_WrData,
   input  logic [DATA_WIDTH-1:0] RF_RdData,
   input  logic                  RF_RdData_VLD,
   output logic                  ALU_EN,
   output logic [3:0]            ALU_FUN,
   input  logic [ALU_WIDTH-1:0]  ALU_OUT,
   input  logic                  ALU_OUT_VLD,
   output logic                  CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_BUSY
);

   localparam int RES_W = 2 * DATA_WIDTH;

   localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
      S_ALU_OPA, S_ALU_OPB, S_ALU_FUN, S_ALU_WAIT, S_TX_LSB, S_TX_MSB
   } state_t;

   state_t                r_state;
   logic                  r_rx_vld_d;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [RES_W-1:0]      r_res;
   logic                  r_is_alu;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_wr_en;
   logic                  r_rd_en;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_alu_en;
   logic [3:0]            r_alu_fun;
   logic                  r_clk_gate;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_tx_vld;

   // A byte is consumed only on the rising edge of RX_D_VLD, so a held
   // strobe can never be taken as a second byte.
   logic w_rx_evt;
   assign w_rx_evt = RX_D_VLD & ~r_rx_vld_d;

   assign RF_Address  = r_addr;
   assign RF_WrEn     = r_wr_en;
   assign RF_RdEn     = r_rd_en;
   assign RF_WrData   = r_wdata;
   assign ALU_EN      = r_alu_en;
   assign ALU_FUN     = r_alu_fun;
   assign CLK_GATE_EN = r_clk_gate;
   assign TX_P_DATA   = r_tx_data;
   assign TX_D_VLD    = r_tx_vld;

   // Frame decoder FSM with registered strobes, operands and TX handshake.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= S_IDLE;
         r_rx_vld_d <= 1'b0;
         r_wr_addr  <= '0;
         r_res      <= '0;
         r_is_alu   <= 1'b0;
         r_addr     <= '0;
         r_wr_en    <= 1'b0;
         r_rd_en    <= 1'b0;
         r_wdata    <= '0;
         r_alu_en   <= 1'b0;
         r_alu_fun  <= '0;
         r_clk_gate <= 1'b0;
         r_tx_data  <= '0;
         r_tx_vld   <= 1'b0;
      end else begin
         r_rx_vld_d <= RX_D_VLD;
         r_wr_en    <= 1'b0;
         r_rd_en    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rx_evt) begin
                  case (RX_P_DATA)
                     CMD_WR: r_state <= S_WR_ADDR;
                     CMD_RD: r_state <= S_RD_ADDR;
                     CMD_ALU_OP: begin
                        r_state    <= S_ALU_OPA;
                        r_clk_gate <= 1'b1;
                     end
                     CMD_ALU_NOP: begin
                        r_state    <= S_ALU_FUN;
                        r_clk_gate <= 1'b1;
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
            S_WR_ADDR: begin
               if (w_rx_evt) begin
                  r_wr_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
                  r_state   <= S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               if (w_rx_evt) begin
                  r_addr  <= r_wr_addr;
                  r_wdata <= RX_P_DATA;
                  r_wr_en <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            S_RD_ADDR: begin
               if (w_rx_evt) begin
                  r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                  r_rd_en <= 1'b1;
                  r_state <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (RF_RdData_VLD) begin
                  r_res    <= RES_W'(RF_RdData);
                  r_is_alu <= 1'b0;
                  r_state  <= S_TX_LSB;
               end
            end
            S_ALU_OPA: begin
               if (w_rx_evt) begin
                  r_addr  <= '0;
                  r_wdata <= RX_P_DATA;
                  r_wr_en <= 1'b1;
                  r_state <= S_ALU_OPB;
               end
            end
            S_ALU_OPB: begin
               if (w_rx_evt) begin
                  r_addr  <= ADDR_WIDTH'(1);
                  r_wdata <= RX_P_DATA;
                  r_wr_en <= 1'b1;
                  r_state <= S_ALU_FUN;
               end
            end
            S_ALU_FUN: begin
               if (w_rx_evt) begin
                  r_alu_fun <= RX_P_DATA[3:0];
                  r_alu_en  <= 1'b1;
                  r_state   <= S_ALU_WAIT;
               end
            end
            S_ALU_WAIT: begin
               if (ALU_OUT_VLD) begin
                  r_res      <= RES_W'(ALU_OUT);
                  r_is_alu   <= 1'b1;
                  r_alu_en   <= 1'b0;
                  r_clk_gate <= 1'b0;
                  r_state    <= S_TX_LSB;
               end
            end
            S_TX_LSB: begin
               if (!r_tx_vld) begin
                  if (!TX_BUSY) begin
                     r_tx_vld  <= 1'b1;
                     r_tx_data <= r_res[DATA_WIDTH-1:0];
                  end
               end else if (TX_BUSY) begin
                  r_tx_vld <= 1'b0;
                  r_state  <= r_is_alu ? S_TX_MSB : S_IDLE;
               end
            end
            S_TX_MSB: begin
               if (!r_tx_vld) begin
                  if (!TX_BUSY) begin
                     r_tx_vld  <= 1'b1;
                     r_tx_data <= r_res[RES_W-1:DATA_WIDTH];
                  end
               end else if (TX_BUSY) begin
                  r_tx_vld <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// tb_sys_cmd_decoder: scoreboard bench with register-file, ALU and
// transmitter responders around sys_cmd_decoder.
module tb_sys_cmd_decoder;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic [3:0]  RF_Address;
   logic        RF_WrEn;
   logic        RF_RdEn;
   logic [7:0]  RF_WrData;
   logic [7:0]  RF_RdData = '0;
   logic        RF_RdData_VLD = 1'b0;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VLD = 1'b0;
   logic        CLK_GATE_EN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        TX_BUSY;

   logic busy_auto  = 1'b0;
   logic busy_force = 1'b0;
   assign TX_BUSY = busy_auto | busy_force;

   int n_pass   = 0;
   int n_checks = 0;

   logic [7:0] exp_wr_addr[$];
   logic [7:0] exp_wr_data[$];
   logic [7:0] exp_rd_addr[$];
   logic [7:0] exp_tx[$];
   logic [7:0] mem [16];
   bit         tx_auto = 1'b1;
   int         tx_hold = 3;

   sys_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_WIDTH(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
      .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .TX_BUSY(TX_BUSY)
   );

   always #5 CLK = ~CLK;

   function automatic int pending();
      return exp_wr_addr.size() + exp_rd_addr.size() + exp_tx.size();
   endfunction

   // Register-file strobe monitor: pops expected writes/reads.
   initial begin : rf_monitor
      logic       prev_wr;
      logic [7:0] ea, ed;
      prev_wr = 1'b0;
      forever begin
         @(negedge CLK);
         if (RF_WrEn || RF_RdEn) begin
            n_checks++;
            if (RF_WrEn && RF_RdEn) $display("FAIL rf_exclusive: WrEn=1 RdEn=1, required not both");
            else n_pass++;
         end
         if (RF_WrEn) begin
            n_checks++;
            if (prev_wr) $display("FAIL wr_single_cycle: WrEn high two cycles in a row");
            else n_pass++;
            n_checks++;
            if (exp_wr_addr.size() == 0) begin
               $display("FAIL wr_unexpected: write addr=%0h data=%02h, required none", RF_Address, RF_WrData);
            end else begin
               ea = exp_wr_addr.pop_front();
               ed = exp_wr_data.pop_front();
               if ({4'h0, RF_Address} !== ea || RF_WrData !== ed)
                  $display("FAIL wr_data: got %02h@%0h, required %02h@%0h", RF_WrData, RF_Address, ed, ea);
               else n_pass++;
            end
            mem[RF_Address] = RF_WrData;
         end
         if (RF_RdEn) begin
            n_checks++;
            if (exp_rd_addr.size() == 0) begin
               $display("FAIL rd_unexpected: read addr=%0h, required none", RF_Address);
            end else begin
               ea = exp_rd_addr.pop_front();
               if ({4'h0, RF_Address} !== ea)
                  $display("FAIL rd_addr: got %0h, required %0h", RF_Address, ea);
               else n_pass++;
            end
         end
         prev_wr = RF_WrEn;
      end
   end

   // Register-file read responder: data valid one cycle after RdEn.
   initial begin : rf_responder
      logic [3:0] a;
      forever begin
         @(negedge CLK);
         if (RF_RdEn) begin
            a = RF_Address;
            @(posedge CLK); #1;
            RF_RdData = mem[a];
            RF_RdData_VLD = 1'b1;
            @(posedge CLK); #1;
            RF_RdData_VLD = 1'b0;
         end
      end
   end

   // Transmitter responder: accepts a byte, raises busy, checks the handshake.
   initial begin : tx_responder
      logic [7:0] d, e;
      forever begin
         @(negedge CLK);
         if (tx_auto && TX_D_VLD && !TX_BUSY) begin
            d = TX_P_DATA;
            n_checks++;
            if (exp_tx.size() == 0) begin
               $display("FAIL tx_unexpected: byte %02h, required none", d);
            end else begin
               e = exp_tx.pop_front();
               if (d !== e) $display("FAIL tx_byte: got %02h, required %02h", d, e);
               else n_pass++;
            end
            @(posedge CLK); #1;
            busy_auto = 1'b1;
            @(negedge CLK);
            n_checks++;
            if (TX_D_VLD !== 1'b1 || TX_P_DATA !== d)
               $display("FAIL tx_hold: vld=%b data=%02h, required vld=1 data=%02h", TX_D_VLD, TX_P_DATA, d);
            else n_pass++;
            @(negedge CLK);
            n_checks++;
            if (TX_D_VLD !== 1'b0) $display("FAIL tx_drop: vld=%b, required 0", TX_D_VLD);
            else n_pass++;
            repeat (tx_hold) @(posedge CLK);
            #1 busy_auto = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, input int hold = 1);
      @(posedge CLK); #1;
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      for (int i = 1; i < hold; i++) @(posedge CLK);
      @(posedge CLK); #1;
      RX_D_VLD = 1'b0;
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while (pending() != 0 && cyc < 400) begin
         @(negedge CLK);
         cyc++;
      end
      repeat (tx_hold + 8) @(negedge CLK);
   endtask

   task automatic wait_alu_en(output bit ok);
      int cyc;
      cyc = 0;
      while (ALU_EN !== 1'b1 && cyc < 50) begin
         @(negedge CLK);
         cyc++;
      end
      ok = (ALU_EN === 1'b1);
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
      exp_wr_addr.push_back(a);
      exp_wr_data.push_back(d);
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD} !== 5'b0)
         $display("FAIL reset_strobes: got %b, required 00000", {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD});
      else n_pass++;
      n_checks++;
      if ({RF_Address, RF_WrData, ALU_FUN, TX_P_DATA} !== 24'h0)
         $display("FAIL reset_data: got %06h, required 000000", {RF_Address, RF_WrData, ALU_FUN, TX_P_DATA});
      else n_pass++;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_write();
      push_wr(8'h05, 8'h0A);
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h0A);
      wait_idle();
      n_checks++;
      if (pending() != 0) $display("FAIL write_pending: %0d outstanding, required 0", pending());
      else n_pass++;
   endtask

   task automatic test_read();
      exp_rd_addr.push_back(8'h05);
      exp_tx.push_back(8'h0A);
      send_byte(8'hBB); send_byte(8'h05);
      wait_idle();
      n_checks++;
      if (pending() != 0) $display("FAIL read_pending: %0d outstanding, required 0", pending());
      else n_pass++;
   endtask

   task automatic test_alu_cc();
      bit ok;
      n_checks++;
      if (CLK_GATE_EN !== 1'b0) $display("FAIL cc_gate_idle: got %b, required 0", CLK_GATE_EN);
      else n_pass++;
      push_wr(8'h00, 8'h01);
      push_wr(8'h01, 8'h02);
      exp_tx.push_back(8'h03);
      exp_tx.push_back(8'h00);
      send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
      wait_alu_en(ok);
      n_checks++;
      if (!ok) $display("FAIL cc_alu_en: ALU_EN=%b after timeout, required 1", ALU_EN);
      else n_pass++;
      n_checks++;
      if (ALU_FUN !== 4'h0 || CLK_GATE_EN !== 1'b1)
         $display("FAIL cc_fun_gate: fun=%0h gate=%b, required fun=0 gate=1", ALU_FUN, CLK_GATE_EN);
      else n_pass++;
      repeat (3) @(negedge CLK);
      n_checks++;
      if (ALU_EN !== 1'b1) $display("FAIL cc_alu_en_hold: got %b, required 1", ALU_EN);
      else n_pass++;
      @(posedge CLK); #1;
      ALU_OUT = 16'h0003;
      ALU_OUT_VLD = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (CLK_GATE_EN !== 1'b1) $display("FAIL cc_gate_vld_cycle: got %b, required 1", CLK_GATE_EN);
      else n_pass++;
      @(posedge CLK); #1;
      ALU_OUT_VLD = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (ALU_EN !== 1'b0 || CLK_GATE_EN !== 1'b0)
         $display("FAIL cc_release: en=%b gate=%b, required 0 0", ALU_EN, CLK_GATE_EN);
      else n_pass++;
      wait_idle();
      n_checks++;
      if (pending() != 0) $display("FAIL cc_pending: %0d outstanding, required 0", pending());
      else n_pass++;
   endtask

   task automatic test_alu_dd(input logic [7:0] fun, input logic [15:0] res);
      bit ok;
      exp_tx.push_back(res[7:0]);
      exp_tx.push_back(res[15:8]);
      send_byte(8'hDD); send_byte(fun);
      wait_alu_en(ok);
      n_checks++;
      if (!ok || ALU_FUN !== fun[3:0] || CLK_GATE_EN !== 1'b1)
         $display("FAIL dd_fun: en=%b fun=%0h gate=%b, required en=1 fun=%0h gate=1", ALU_EN, ALU_FUN, CLK_GATE_EN, fun[3:0]);
      else n_pass++;
      @(posedge CLK); #1;
      ALU_OUT = res;
      ALU_OUT_VLD = 1'b1;
      @(posedge CLK); #1;
      ALU_OUT_VLD = 1'b0;
      wait_idle();
      n_checks++;
      if (pending() != 0) $display("FAIL dd_pending: %0d outstanding, required 0", pending());
      else n_pass++;
   endtask

   task automatic test_ignore_cmd();
      send_byte(8'h55);
      repeat (4) @(negedge CLK);
      n_checks++;
      if ({RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD} !== 5'b0)
         $display("FAIL ignore_55: strobes %b, required 00000", {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD});
      else n_pass++;
      push_wr(8'h03, 8'h7E);
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h7E);
      wait_idle();
      n_checks++;
      if (pending() != 0) $display("FAIL ignore_pending: %0d outstanding, required 0", pending());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      push_wr(8'h09, 8'h5A);
      push_wr(8'h02, 8'hC3);
      send_byte(8'hAA); send_byte(8'h09); send_byte(8'h5A, 4);
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'hC3);
      exp_rd_addr.push_back(8'h09);
      exp_tx.push_back(8'h5A);
      send_byte(8'hBB); send_byte(8'h09);
      send_byte(8'hAA);
      wait_idle();
      push_wr(8'h04, 8'h11);
      send_byte(8'hAA); send_byte(8'h04); send_byte(8'h11);
      wait_idle();
      n_checks++;
      if (pending() != 0) $display("FAIL b2b_pending: %0d outstanding, required 0", pending());
      else n_pass++;
   endtask

   task automatic test_reset_alu_wait();
      bit ok;
      send_byte(8'hDD); send_byte(8'h02);
      wait_alu_en(ok);
      n_checks++;
      if (!ok) $display("FAIL rst_alu_en: ALU_EN=%b after timeout, required 1", ALU_EN);
      else n_pass++;
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      n_checks++;
      if ({RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, RF_Address, RF_WrData, ALU_FUN, TX_P_DATA} !== 29'h0)
         $display("FAIL rst_alu_outputs: got %08h, required 0", {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, RF_Address, RF_WrData, ALU_FUN, TX_P_DATA});
      else n_pass++;
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
      exp_rd_addr.push_back(8'h05);
      exp_tx.push_back(8'h0A);
      send_byte(8'hBB); send_byte(8'h05);
      wait_idle();
      n_checks++;
      if (pending() != 0) $display("FAIL rst_alu_pending: %0d outstanding, required 0", pending());
      else n_pass++;
   endtask

   task automatic test_reset_handshake();
      int cyc;
      tx_auto = 1'b0;
      exp_rd_addr.push_back(8'h05);
      send_byte(8'hBB); send_byte(8'h05);
      cyc = 0;
      while (TX_D_VLD !== 1'b1 && cyc < 50) begin
         @(negedge CLK);
         cyc++;
      end
      n_checks++;
      if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h0A)
         $display("FAIL rst_hs_start: vld=%b data=%02h, required vld=1 data=0a", TX_D_VLD, TX_P_DATA);
      else n_pass++;
      @(posedge CLK); #1;
      busy_force = 1'b1;
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      n_checks++;
      if (TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'h00 || RF_Address !== 4'h0)
         $display("FAIL rst_hs_outputs: vld=%b data=%02h addr=%0h, required 0 00 0", TX_D_VLD, TX_P_DATA, RF_Address);
      else n_pass++;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      busy_force = 1'b0;
      tx_auto = 1'b1;
      exp_rd_addr.push_back(8'h05);
      exp_tx.push_back(8'h0A);
      send_byte(8'hBB); send_byte(8'h05);
      wait_idle();
      n_checks++;
      if (pending() != 0) $display("FAIL rst_hs_pending: %0d outstanding, required 0", pending());
      else n_pass++;
   endtask

   initial begin : main
      test_reset();
      test_write();
      test_read();
      test_alu_cc();
      test_alu_dd(8'h02, 16'h0002);
      test_ignore_cmd();
      test_back_to_back();
      test_alu_dd(8'h07, 16'hBEEF);
      test_reset_alu_wait();
      test_reset_handshake();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sys_cmd_decoder.md
SYS_CMD_DECODER -- requirements
Module: sys_cmd_decoder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_WIDTH, 8, byte width; ADDR_WIDTH, 4, register-file address width; ALU_WIDTH, 16, ALU result width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- CLK in 1: reference clock.
- RST_N in 1: async active-low reset.
- RX_P_DATA in DATA_WIDTH: received byte.
- RX_D_VLD in 1: one-cycle pulse; RX_P_DATA is valid.
- RF_Address out ADDR_WIDTH: register-file address.
- RF_WrEn out 1: register-file write strobe.
- RF_RdEn out 1: register-file read strobe.
- RF_WrData out DATA_WIDTH: register-file write data.
- RF_RdData in DATA_WIDTH: register-file read data.
- RF_RdData_VLD in 1: read data valid.
- ALU_EN out 1: ALU enable.
- ALU_FUN out 4: ALU function select.
- ALU_OUT in ALU_WIDTH: ALU result.
- ALU_OUT_VLD in 1: ALU result valid.
- CLK_GATE_EN out 1: ALU clock-gate enable.
- TX_P_DATA out DATA_WIDTH: byte to transmit.
- TX_D_VLD out 1: transmit request.
- TX_BUSY in 1: transmitter busy.

Function
REQ-004 The block SHALL treat the first byte of each frame as the command: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands.
REQ-005 The FSM SHALL have these states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_OPA, ALU_OPB, ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB.
REQ-006 In IDLE, on RX_D_VLD, the FSM SHALL move to WR_ADDR for 0xAA, RD_ADDR for 0xBB, ALU_OPA for 0xCC, and ALU_FUN for 0xDD.
REQ-007 The FSM SHALL stay in IDLE, with no output activity, on any other command byte.
REQ-008 In WR_ADDR, on RX_D_VLD, the block SHALL latch RX_P_DATA[ADDR_WIDTH-1:0] as the address and move to WR_DATA.
REQ-009 In WR_DATA, on RX_D_VLD, the block SHALL drive RF_Address and RF_WrData, pulse RF_WrEn high for exactly one cycle in the next cycle, and return to IDLE.
REQ-010 In RD_ADDR, on RX_D_VLD, the block SHALL pulse RF_RdEn for one cycle in the next cycle with RF_Address set to the byte's low bits, then move to RD_WAIT.
REQ-011 In RD_WAIT, on RF_RdData_VLD, the block SHALL capture RF_RdData as a single byte to send and move to TX_LSB.
REQ-012 In ALU_OPA and ALU_OPB, on each RX_D_VLD, the block SHALL issue a one-cycle RF_WrEn with RF_Address 0 (OPA) or 1 (OPB) and RF_WrData equal to the byte.
REQ-013 ALU_OPA SHALL move to ALU_OPB, and ALU_OPB SHALL move to ALU_FUN.
REQ-014 In ALU_FUN, on RX_D_VLD, the block SHALL latch ALU_FUN from RX_P_DATA[3:0], assert ALU_EN, and move to ALU_WAIT.
REQ-015 ALU_EN SHALL stay high until ALU_OUT_VLD.
REQ-016 CLK_GATE_EN SHALL be high from the cycle after an accepted 0xCC/0xDD command byte until the cycle after ALU_OUT_VLD.
REQ-017 In ALU_WAIT, on ALU_OUT_VLD, the block SHALL capture ALU_OUT as two bytes to send, deassert ALU_EN, and move to TX_LSB.
REQ-018 Transmit handshake: TX_D_VLD SHALL be asserted only while TX_BUSY=0 and SHALL be held high, with TX_P_DATA stable, until TX_BUSY is sampled high; it SHALL then drop in the following cycle.
REQ-019 TX_LSB SHALL send the captured byte, or ALU_OUT[7:0] for ALU frames.
REQ-020 For read frames, TX_LSB SHALL return to IDLE after the handshake completes.
REQ-021 For ALU frames, TX_LSB SHALL move to TX_MSB; TX_MSB SHALL wait for TX_BUSY=0, send ALU_OUT[15:8] with the same handshake, then return to IDLE.
REQ-022 RX_D_VLD SHALL be ignored in RD_WAIT, ALU_WAIT, TX_LSB and TX_MSB; no buffering is required.
REQ-023 RF_WrEn and RF_RdEn SHALL never be high in the same cycle.
REQ-024 A one-cycle RF_WrEn SHALL never repeat for the same byte, even if RX_D_VLD is held high for more than one cycle; the FSM advances on the first cycle only.
REQ-025 Unused ALU_OUT MSB bits SHALL be sent as-is; no truncation or saturation is applied.

Reset
REQ-026 While RST_N=0, the FSM SHALL be in IDLE, and RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN and TX_D_VLD SHALL be 0.
REQ-027 While RST_N=0, RF_Address, RF_WrData, ALU_FUN, TX_P_DATA and all capture registers SHALL be 0.
REQ-028 Reset asserted mid-frame, including mid-handshake, SHALL abandon the frame immediately; after release, the next byte SHALL be interpreted as a command.

Verification
REQ-029 The bench SHALL cover: bytes 0xAA, 0x05, 0x0A -> a single-cycle RF_WrEn with RF_Address=5 and RF_WrData=0x0A; no TX_D_VLD.
REQ-030 The bench SHALL cover: 0xBB, 0x05 with RF_RdData=0x0A -> an RF_RdEn pulse at address 5, then one TX frame with TX_P_DATA=0x0A, then IDLE.
REQ-031 The bench SHALL cover: 0xCC, 0x01, 0x02, 0x00 with ALU_OUT=0x0003 -> writes 0x01@0 and 0x02@1, ALU_FUN=0, CLK_GATE_EN high, then TX bytes 0x03 and 0x00 in order.
REQ-032 The bench SHALL cover: 0xDD, 0x02 with ALU_OUT=0x0002 -> no RF writes, ALU_FUN=2, TX bytes 0x02 then 0x00.
REQ-033 The bench SHALL cover: byte 0x55 in IDLE, then 0xAA, 0x03, 0x7E -> 0x55 ignored, write 0x7E@3.
REQ-034 The bench SHALL cover: RST_N pulsed low in ALU_WAIT and during a TX_BUSY-held handshake -> all outputs return to reset values, and the next 0xBB frame completes normally.
